trace_link_ctrl: RTL and testbench

- Sits between traceIF, the UART and the host link.
- Decodes host command bytes from the UART receiver to configure trace port width and enable.
- Buffers trace bytes from traceIF in a small FIFO.
- Arbitrates the single UART transmitter between command responses (priority) and buffered trace data, sequencing each byte through the UART transmit handshake.

---
 rtl/trace_link_pkg.sv | 37 +++
 rtl/sync_fifo.sv | 52 +++++
 rtl/trace_link_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_trace_link_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_link_pkg.sv
// Shared constants for the trace link controller: host opcodes, reply bytes,
// FSM state encodings and the status-byte layout.
package trace_link_pkg;

  localparam logic [7:0] OP_WIDTH = 8'h57;
  localparam logic [7:0] OP_EN    = 8'h45;
  localparam logic [7:0] OP_STAT  = 8'h53;
  localparam logic [7:0] OP_VER   = 8'h56;
  localparam logic [7:0] ACK      = 8'h06;
  localparam logic [7:0] NAK      = 8'h15;

  localparam logic [0:0] P_IDLE = 1'b0;
  localparam logic [0:0] P_ARG  = 1'b1;

  localparam logic [1:0] T_IDLE    = 2'd0;
  localparam logic [1:0] T_START   = 2'd1;
  localparam logic [1:0] T_WAIT_HI = 2'd2;
  localparam logic [1:0] T_WAIT_LO = 2'd3;

  localparam int ST_OVF   = 7;
  localparam int ST_EN    = 6;
  localparam int ST_EMPTY = 5;
  localparam int ST_LOST  = 4;

  function automatic logic [7:0] status_byte(input logic ovf, input logic en,
                                             input logic empty, input logic lost,
                                             input logic [1:0] w);
    logic [7:0] s;
    s           = {6'b0, w};
    s[ST_OVF]   = ovf;
    s[ST_EN]    = en;
    s[ST_EMPTY] = empty;
    s[ST_LOST]  = lost;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data.
// Push when full and pop when empty are ignored.
module sync_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == DEPTH);
  assign empty   = (cnt_q == '0);
  assign rdata   = mem[rptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    wptr_d = wptr_q + AW'(do_push);
    rptr_d = rptr_q + AW'(do_pop);
    cnt_d  = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= wdata;
  end

endmodule

// File: rtl/trace_link_ctrl.sv
// Host command parser, trace byte buffer and UART transmit arbiter.
// Command replies always win over trace data, but only between bytes.
module trace_link_ctrl
  import trace_link_pkg::*;
#(
  parameter int         FIFO_AW       = 4,
  parameter int         ARG_TIMEOUT   = 480000,
  parameter logic [7:0] VERSION       = 8'h01,
  parameter logic [1:0] DEFAULT_WIDTH = 2'b11,
  parameter logic       DEFAULT_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_strobe,
  input  logic [7:0] rx_byte,
  input  logic       rx_err,
  input  logic       trace_dvalid,
  input  logic [7:0] trace_byte,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  output logic [1:0] width,
  output logic       trace_en,
  output logic       ovf
);

  localparam int TW = (ARG_TIMEOUT > 1) ? $clog2(ARG_TIMEOUT) : 1;

  logic [0:0]    ps_q, ps_d;
  logic [7:0]    op_q, op_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    width_q, width_d;
  logic          en_q, en_d, ovf_q, ovf_d, lost_q, lost_d;
  logic          resp_full_q, resp_full_d;
  logic [7:0]    resp_q, resp_d, resp_val;
  logic          resp_push, resp_pop, stat_clr;
  logic [1:0]    arb_q, arb_d, wcnt_q, wcnt_d;
  logic [7:0]    txb_q, txb_d;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, tx_lost;
  logic [7:0]    fifo_rdata;

  assign fifo_push = trace_dvalid & en_q & ~fifo_full;

  sync_fifo #(.W(8), .AW(FIFO_AW)) u_fifo (
    .clk(clk), .rst(rst), .push(fifo_push), .wdata(trace_byte), .pop(fifo_pop),
    .rdata(fifo_rdata), .full(fifo_full), .empty(fifo_empty)
  );

  always_comb begin
    ps_d      = ps_q;
    op_d      = op_q;
    timer_d   = timer_q;
    width_d   = width_q;
    en_d      = en_q;
    resp_push = 1'b0;
    resp_val  = NAK;
    stat_clr  = 1'b0;
    if (rx_err) begin
      resp_push = 1'b1;
      ps_d      = P_IDLE;
    end else if (ps_q == P_IDLE) begin
      if (rx_strobe) begin
        case (rx_byte)
          OP_WIDTH, OP_EN: begin
            op_d    = rx_byte;
            timer_d = '0;
            ps_d    = P_ARG;
          end
          OP_STAT: begin
            resp_push = 1'b1;
            resp_val  = status_byte(ovf_q, en_q, fifo_empty, lost_q, width_q);
            stat_clr  = 1'b1;
          end
          OP_VER:  begin resp_push = 1'b1; resp_val = VERSION; end
          default: resp_push = 1'b1;
        endcase
      end
    end else begin
      if (rx_strobe) begin
        resp_push = 1'b1;
        ps_d      = P_IDLE;
        if (op_q == OP_WIDTH && rx_byte <= 8'd3) begin
          width_d  = rx_byte[1:0];
          resp_val = ACK;
        end else if (op_q == OP_EN && rx_byte <= 8'd1) begin
          en_d     = rx_byte[0];
          resp_val = ACK;
        end
      end else if (timer_q == TW'(ARG_TIMEOUT - 1)) begin
        resp_push = 1'b1;
        ps_d      = P_IDLE;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_comb begin
    arb_d    = arb_q;
    txb_d    = txb_q;
    wcnt_d   = wcnt_q;
    resp_pop = 1'b0;
    fifo_pop = 1'b0;
    tx_lost  = 1'b0;
    case (arb_q)
      T_IDLE: if (!tx_busy) begin
        if (resp_full_q) begin
          txb_d    = resp_q;
          resp_pop = 1'b1;
          arb_d    = T_START;
        end else if (!fifo_empty) begin
          txb_d    = fifo_rdata;
          fifo_pop = 1'b1;
          arb_d    = T_START;
        end
      end
      T_START: begin
        arb_d  = T_WAIT_HI;
        wcnt_d = '0;
      end
      // A UART that never raises busy has eaten the byte; count it as lost.
      T_WAIT_HI: begin
        if (tx_busy) arb_d = T_WAIT_LO;
        else if (wcnt_q == 2'd3) begin
          arb_d   = T_IDLE;
          tx_lost = 1'b1;
        end else wcnt_d = wcnt_q + 2'd1;
      end
      default: if (!tx_busy) arb_d = T_IDLE;
    endcase
  end

  // Slot freed by the arbiter this cycle can take a new reply immediately.
  always_comb begin
    resp_full_d = resp_full_q & ~resp_pop;
    resp_d      = resp_q;
    lost_d      = lost_q & ~stat_clr;
    ovf_d       = ovf_q & ~stat_clr;
    if (resp_push) begin
      if (!resp_full_q || resp_pop) begin
        resp_full_d = 1'b1;
        resp_d      = resp_val;
      end else lost_d = 1'b1;
    end
    if ((trace_dvalid & en_q & fifo_full) | tx_lost) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q        <= P_IDLE;
      op_q        <= '0;
      timer_q     <= '0;
      width_q     <= DEFAULT_WIDTH;
      en_q        <= DEFAULT_EN;
      ovf_q       <= 1'b0;
      lost_q      <= 1'b0;
      resp_full_q <= 1'b0;
      resp_q      <= '0;
      arb_q       <= T_IDLE;
      wcnt_q      <= '0;
      txb_q       <= '0;
    end else begin
      ps_q        <= ps_d;
      op_q        <= op_d;
      timer_q     <= timer_d;
      width_q     <= width_d;
      en_q        <= en_d;
      ovf_q       <= ovf_d;
      lost_q      <= lost_d;
      resp_full_q <= resp_full_d;
      resp_q      <= resp_d;
      arb_q       <= arb_d;
      wcnt_q      <= wcnt_d;
      txb_q       <= txb_d;
    end
  end

  assign tx_start = (arb_q == T_START);
  assign tx_byte  = txb_q;
  assign width    = width_q;
  assign trace_en = en_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_trace_link_ctrl.sv
// Directed bench for trace_link_ctrl: cycle-exact vector table, then
// multi-cycle sequences against a simple busy-for-10-cycles UART model.
module tb_trace_link_ctrl;

  logic       clk = 1'b0;
  logic       rst, rx_strobe, rx_err, trace_dvalid, tx_busy, tx_start, trace_en, ovf;
  logic [7:0] rx_byte, trace_byte, tx_byte;
  logic [1:0] width;

  logic       uart_auto = 1'b0, busy_man = 1'b0, busy_auto = 1'b0;
  int         busy_cnt = 0, n_start = 0;
  logic [7:0] got [$];
  int         checks = 0, failures = 0;

  always #5 clk = ~clk;
  assign tx_busy = uart_auto ? busy_auto : busy_man;

  trace_link_ctrl #(.ARG_TIMEOUT(100)) dut (
    .clk(clk), .rst(rst), .rx_strobe(rx_strobe), .rx_byte(rx_byte), .rx_err(rx_err),
    .trace_dvalid(trace_dvalid), .trace_byte(trace_byte), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_byte(tx_byte), .width(width), .trace_en(trace_en), .ovf(ovf)
  );

  // UART model: capture byte at tx_start, then stay busy for 10 cycles.
  always @(negedge clk) begin
    if (tx_start) begin
      n_start <= n_start + 1;
      if (uart_auto) begin
        got.push_back(tx_byte);
        busy_cnt  <= 10;
        busy_auto <= 1'b1;
      end
    end else if (busy_cnt > 1) busy_cnt <= busy_cnt - 1;
    else begin
      busy_cnt  <= 0;
      busy_auto <= 1'b0;
    end
  end

  typedef struct {
    logic       strb; logic [7:0] rxb; logic dv; logic [7:0] tb; logic busy;
    logic       e_start; logic [7:0] e_byte; logic [1:0] e_w; logic e_en; logic e_ovf;
  } vec_t;
  vec_t tbl [$];

  function automatic vec_t mk(logic s, logic [7:0] rb, logic d, logic [7:0] t, logic b,
                              logic es, logic [7:0] eb, logic [1:0] ew, logic een, logic eo);
    vec_t v;
    v.strb = s; v.rxb = rb; v.dv = d; v.tb = t; v.busy = b;
    v.e_start = es; v.e_byte = eb; v.e_w = ew; v.e_en = een; v.e_ovf = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic err);
    @(negedge clk);
    rx_strobe = 1'b1; rx_byte = b; rx_err = err;
    @(negedge clk);
    rx_strobe = 1'b0; rx_err = 1'b0;
  endtask

  task automatic wait_got(input string nm, input int n, input int bound);
    for (int c = 0; c < bound && got.size() < n; c++) @(negedge clk);
    chk(nm, got.size(), n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_pre [5];
    int s0;
    rst = 1'b1; rx_strobe = 1'b0; rx_byte = '0; rx_err = 1'b0;
    trace_dvalid = 1'b0; trace_byte = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_start", tx_start, 0); chk("rst_tx_byte", tx_byte, 0);
    chk("rst_width", width, 3); chk("rst_en", trace_en, 1); chk("rst_ovf", ovf, 0);
    @(negedge clk) rst = 1'b0;

    // strb rxb dv tb busy | start byte w en ovf  (state after the edge)
    tbl.push_back(mk(1,8'h57,0,8'h00,0, 0,8'h00,3,1,0));
    tbl.push_back(mk(1,8'h01,0,8'h00,0, 0,8'h00,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 1,8'h06,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h06,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h06,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h06,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h06,1,1,0));
    tbl.push_back(mk(1,8'h45,0,8'h00,0, 0,8'h06,1,1,0));
    tbl.push_back(mk(1,8'h00,0,8'h00,0, 0,8'h06,1,0,0));
    tbl.push_back(mk(0,8'h00,1,8'hAA,0, 1,8'h06,1,0,0));
    tbl.push_back(mk(0,8'h00,1,8'hAB,0, 0,8'h06,1,0,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h06,1,0,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h06,1,0,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h06,1,0,0));
    tbl.push_back(mk(1,8'h45,0,8'h00,0, 0,8'h06,1,0,0));
    tbl.push_back(mk(1,8'h01,0,8'h00,0, 0,8'h06,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 1,8'h06,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h06,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h06,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h06,1,1,0));
    tbl.push_back(mk(0,8'h00,1,8'h5A,0, 0,8'h06,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 1,8'h5A,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h5A,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h5A,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h5A,1,1,0));
    tbl.push_back(mk(1,8'h57,0,8'h00,0, 0,8'h5A,1,1,0));
    tbl.push_back(mk(1,8'h04,0,8'h00,0, 0,8'h5A,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 1,8'h15,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h15,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h15,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h15,1,1,0));
    tbl.push_back(mk(1,8'h56,0,8'h00,0, 0,8'h15,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 1,8'h01,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h01,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h01,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h01,1,1,0));
    tbl.push_back(mk(1,8'h41,0,8'h00,1, 0,8'h01,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h01,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 1,8'h15,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h15,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,1, 0,8'h15,1,1,0));
    tbl.push_back(mk(0,8'h00,0,8'h00,0, 0,8'h15,1,1,0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rx_strobe = tbl[i].strb; rx_byte = tbl[i].rxb;
      trace_dvalid = tbl[i].dv; trace_byte = tbl[i].tb; busy_man = tbl[i].busy;
      @(posedge clk); #1;
      chk($sformatf("v%0d_tx_start", i), tx_start, tbl[i].e_start);
      chk($sformatf("v%0d_tx_byte", i), tx_byte, tbl[i].e_byte);
      chk($sformatf("v%0d_width", i), width, tbl[i].e_w);
      chk($sformatf("v%0d_en", i), trace_en, tbl[i].e_en);
      chk($sformatf("v%0d_ovf", i), ovf, tbl[i].e_ovf);
    end
    @(negedge clk);
    rx_strobe = 1'b0; trace_dvalid = 1'b0; busy_man = 1'b1;

    // 20-byte burst while the UART is held busy: 16 fit, 4 overflow.
    for (int i = 0; i < 20; i++) begin
      trace_dvalid = 1'b1; trace_byte = 8'h80 + 8'(i);
      @(negedge clk);
    end
    trace_dvalid = 1'b0;
    chk("burst_ovf", ovf, 1);
    got.delete();
    uart_auto = 1'b1;
    wait_got("burst_cnt", 16, 600);
    repeat (40) @(negedge clk);
    chk("burst_cnt_final", got.size(), 16);
    for (int i = 0; i < 16 && i < got.size(); i++)
      chk($sformatf("burst_b%0d", i), got[i], 8'h80 + 8'(i));

    got.delete();
    send(8'h53, 1'b0);
    chk("stat_ovf_clr", ovf, 0);
    wait_got("stat_cnt", 1, 50);
    if (got.size() > 0) chk("stat_byte", got[0], 8'hE1);
    repeat (20) @(negedge clk);

    // Argument timeout: nothing before 100 cycles, then NAK.
    got.delete();
    send(8'h57, 1'b0);
    repeat (94) @(negedge clk);
    chk("tmo_early", got.size(), 0);
    wait_got("tmo_cnt", 1, 60);
    if (got.size() > 0) chk("tmo_nak", got[0], 8'h15);
    repeat (20) @(negedge clk);
    got.delete();
    send(8'h56, 1'b0);
    wait_got("ver_cnt", 1, 20);
    if (got.size() > 0) chk("ver_byte", got[0], 8'h01);
    repeat (20) @(negedge clk);

    // Reply arrives while a trace byte is in flight with 3 more queued.
    got.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      trace_dvalid = 1'b1; trace_byte = 8'hC0 + 8'(i);
    end
    @(negedge clk) trace_dvalid = 1'b0;
    send(8'h56, 1'b0);
    wait_got("pre_cnt", 5, 400);
    exp_pre = '{8'hC0, 8'h01, 8'hC1, 8'hC2, 8'hC3};
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk($sformatf("pre_b%0d", i), got[i], exp_pre[i]);
    repeat (20) @(negedge clk);

    // rx_err wins over a coincident argument byte.
    got.delete();
    send(8'h57, 1'b0);
    send(8'h00, 1'b1);
    wait_got("err_cnt", 1, 20);
    if (got.size() > 0) chk("err_nak", got[0], 8'h15);
    chk("err_width", width, 1);
    repeat (20) @(negedge clk);

    // Reset while waiting for the UART to finish.
    got.delete();
    send(8'h45, 1'b0);
    send(8'h00, 1'b0);
    wait_got("dis_cnt", 1, 20);
    chk("dis_en", trace_en, 0);
    repeat (20) @(negedge clk);
    got.delete();
    send(8'h56, 1'b0);
    wait_got("rst_v_cnt", 1, 20);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_start", tx_start, 0); chk("mid_rst_byte", tx_byte, 0);
    chk("mid_rst_width", width, 3); chk("mid_rst_en", trace_en, 1);
    chk("mid_rst_ovf", ovf, 0);
    @(negedge clk) rst = 1'b0;
    s0 = n_start;
    repeat (30) @(negedge clk);
    chk("mid_rst_no_start", n_start, s0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
